// File: rtl/mcode_pkg.sv
// Shared microcode-store definitions: table geometry, stream constants and
// loader state encoding. Also imported by the microcode read path.
package mcode_pkg;

  localparam int unsigned OPC_ENTRIES = 61;
  localparam int unsigned SUB_ENTRIES = 27;
  localparam int unsigned CTRL_W      = 59;
  localparam int unsigned OPC_AW      = 6;
  localparam int unsigned SUB_AW      = 5;
  localparam int unsigned IDX_W       = 5;
  localparam int unsigned BYTE_W      = 8;
  localparam int unsigned WORD_BYTES  = 8;
  localparam int unsigned BCNT_W      = 3;

  localparam logic [BYTE_W-1:0] HDR_BYTE = 8'hA5;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_HDR,
    ST_OPC,
    ST_SUB,
    ST_CHK,
    ST_DONE,
    ST_ERR
  } state_t;

endpackage

// File: rtl/mcode_word_assembler.sv
// Little-endian byte-to-control-word assembler for the sub-op table.
// The eighth byte is taken straight from the input, so only seven bytes
// are stored; word bits above CTRL_W are padding and are dropped.
module mcode_word_assembler
  import mcode_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr,
  input  logic              en,
  input  logic [BYTE_W-1:0] in_data,
  output logic              word_valid_c,
  output logic [CTRL_W-1:0] word_c
);

  localparam int unsigned SR_W = (WORD_BYTES - 1) * BYTE_W;

  logic [SR_W-1:0]   sr;
  logic [BCNT_W-1:0] byte_cnt;

  // Word completes on the accepted eighth byte.
  assign word_valid_c = en && (byte_cnt == BCNT_W'(WORD_BYTES - 1));
  assign word_c       = {in_data[CTRL_W-SR_W-1:0], sr};

  // Shift new bytes in at the top so byte 0 ends up in the low bits.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sr       <= '0;
      byte_cnt <= '0;
    end else if (clr) begin
      sr       <= '0;
      byte_cnt <= '0;
    end else if (en) begin
      sr       <= {in_data, sr[SR_W-1:BYTE_W]};
      byte_cnt <= byte_cnt + BCNT_W'(1);
    end
  end

endmodule

// File: rtl/microcode_loader.sv
// Microcode store writer: parses the boot byte stream (header, opcode
// indices, sub-op control words) and drives the two table write ports.
// Define MCODE_CHECKSUM_EN to require a trailing mod-256 checksum byte.
module microcode_loader
  import mcode_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [BYTE_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              opc_we,
  output logic [OPC_AW-1:0] opc_waddr,
  output logic [IDX_W-1:0]  opc_wdata,
  output logic              sub_we,
  output logic [SUB_AW-1:0] sub_waddr,
  output logic [CTRL_W-1:0] sub_wdata,
  output logic              busy,
  output logic              done,
  output logic              error
);

  state_t              state_q, state_d;
  logic [OPC_AW-1:0]   opc_cnt_q, opc_cnt_d;
  logic [SUB_AW-1:0]   sub_cnt_q, sub_cnt_d;
  logic                opc_we_d, sub_we_d;
  logic [OPC_AW-1:0]   opc_waddr_d;
  logic [IDX_W-1:0]    opc_wdata_d;
  logic [SUB_AW-1:0]   sub_waddr_d;
  logic [CTRL_W-1:0]   sub_wdata_d;
  logic                active_d, done_d, error_d;
  logic                xfer_c, asm_clr_c, asm_en_c, word_valid_c;
  logic [CTRL_W-1:0]   word_c;
`ifdef MCODE_CHECKSUM_EN
  logic [BYTE_W-1:0]   sum_q, sum_d;
`endif

  assign xfer_c = in_valid && in_ready;

  mcode_word_assembler u_asm (
    .clk          (clk),
    .rst_n        (rst_n),
    .clr          (asm_clr_c),
    .en           (asm_en_c),
    .in_data      (in_data),
    .word_valid_c (word_valid_c),
    .word_c       (word_c)
  );

  // Next-state, counter and write-port decode.
  always_comb begin
    state_d     = state_q;
    opc_cnt_d   = opc_cnt_q;
    sub_cnt_d   = sub_cnt_q;
    opc_we_d    = 1'b0;
    opc_waddr_d = opc_waddr;
    opc_wdata_d = opc_wdata;
    sub_we_d    = 1'b0;
    sub_waddr_d = sub_waddr;
    sub_wdata_d = sub_wdata;
    asm_clr_c   = 1'b0;
    asm_en_c    = 1'b0;
`ifdef MCODE_CHECKSUM_EN
    sum_d       = sum_q;
`endif
    case (state_q)
      ST_IDLE, ST_DONE, ST_ERR: begin
        if (start) begin
          state_d   = ST_HDR;
          opc_cnt_d = '0;
          sub_cnt_d = '0;
          asm_clr_c = 1'b1;
`ifdef MCODE_CHECKSUM_EN
          sum_d     = '0;
`endif
        end
      end
      ST_HDR: begin
        if (xfer_c) state_d = (in_data == HDR_BYTE) ? ST_OPC : ST_ERR;
      end
      ST_OPC: begin
        if (xfer_c) begin
`ifdef MCODE_CHECKSUM_EN
          sum_d = sum_q + in_data;
`endif
          if ((in_data[BYTE_W-1:IDX_W] != '0) || (in_data[IDX_W-1:0] >= IDX_W'(SUB_ENTRIES))) begin
            state_d = ST_ERR;
          end else begin
            opc_we_d    = 1'b1;
            opc_waddr_d = opc_cnt_q;
            opc_wdata_d = in_data[IDX_W-1:0];
            if (opc_cnt_q == OPC_AW'(OPC_ENTRIES - 1)) state_d = ST_SUB;
            else opc_cnt_d = opc_cnt_q + OPC_AW'(1);
          end
        end
      end
      ST_SUB: begin
        if (xfer_c) begin
          asm_en_c = 1'b1;
`ifdef MCODE_CHECKSUM_EN
          sum_d = sum_q + in_data;
`endif
          if (word_valid_c) begin
            sub_we_d    = 1'b1;
            sub_waddr_d = sub_cnt_q;
            sub_wdata_d = word_c;
            if (sub_cnt_q == SUB_AW'(SUB_ENTRIES - 1)) begin
`ifdef MCODE_CHECKSUM_EN
              state_d = ST_CHK;
`else
              state_d = ST_DONE;
`endif
            end else begin
              sub_cnt_d = sub_cnt_q + SUB_AW'(1);
            end
          end
        end
      end
`ifdef MCODE_CHECKSUM_EN
      ST_CHK: begin
        if (xfer_c) state_d = (in_data == sum_q) ? ST_DONE : ST_ERR;
      end
`endif
      default: state_d = state_q;
    endcase
    active_d = (state_d == ST_HDR) || (state_d == ST_OPC) ||
               (state_d == ST_SUB) || (state_d == ST_CHK);
    done_d   = (state_d == ST_DONE);
    error_d  = (state_d == ST_ERR);
  end

  // State, counters and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      opc_cnt_q <= '0;
      sub_cnt_q <= '0;
      in_ready  <= 1'b0;
      opc_we    <= 1'b0;
      opc_waddr <= '0;
      opc_wdata <= '0;
      sub_we    <= 1'b0;
      sub_waddr <= '0;
      sub_wdata <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      error     <= 1'b0;
    end else begin
      state_q   <= state_d;
      opc_cnt_q <= opc_cnt_d;
      sub_cnt_q <= sub_cnt_d;
      in_ready  <= active_d;
      opc_we    <= opc_we_d;
      opc_waddr <= opc_waddr_d;
      opc_wdata <= opc_wdata_d;
      sub_we    <= sub_we_d;
      sub_waddr <= sub_waddr_d;
      sub_wdata <= sub_wdata_d;
      busy      <= active_d;
      done      <= done_d;
      error     <= error_d;
    end
  end

`ifdef MCODE_CHECKSUM_EN
  // Running checksum of post-header bytes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sum_q <= '0;
    else        sum_q <= sum_d;
  end
`endif

endmodule

// File: tb/tb_microcode_loader.sv
// Scoreboard bench for microcode_loader: a stream-level reference model
// queues the expected table writes; a monitor pops and compares them.
module tb_microcode_loader;
  import mcode_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [7:0]  in_data = 8'h00;
  logic        in_valid = 1'b0;
  logic        in_ready, opc_we, sub_we, busy, done, error;
  logic [5:0]  opc_waddr;
  logic [4:0]  opc_wdata, sub_waddr;
  logic [58:0] sub_wdata;

  microcode_loader dut (
    .clk(clk), .rst_n(rst_n), .start(start), .in_data(in_data),
    .in_valid(in_valid), .in_ready(in_ready), .opc_we(opc_we),
    .opc_waddr(opc_waddr), .opc_wdata(opc_wdata), .sub_we(sub_we),
    .sub_waddr(sub_waddr), .sub_wdata(sub_wdata), .busy(busy),
    .done(done), .error(error)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  logic [10:0] exp_opc[$];
  logic [63:0] exp_sub[$];
  logic [7:0]  stream[$];
  int hs, opc_seen, sub_seen, cyc, last_strobe_cyc, fall_cyc;
  logic prev_busy = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Monitor: pop-and-compare on every write strobe, count handshakes.
  always @(negedge clk) begin
    cyc++;
    if (rst_n) begin
      if (in_valid && in_ready) hs++;
      if (opc_we && sub_we) chk("one_strobe", 64'd2, 64'd1);
      if (opc_we) begin
        opc_seen++;
        last_strobe_cyc = cyc;
        if (exp_opc.size() == 0) chk("opc_unexpected", {opc_waddr, opc_wdata}, 64'hDEAD);
        else chk("opc_write", {opc_waddr, opc_wdata}, exp_opc.pop_front());
      end
      if (sub_we) begin
        sub_seen++;
        last_strobe_cyc = cyc;
        if (exp_sub.size() == 0) chk("sub_unexpected", {sub_waddr, sub_wdata}, 64'hDEAD);
        else chk("sub_write", {sub_waddr, sub_wdata}, exp_sub.pop_front());
      end
      if (prev_busy && !busy) fall_cyc = cyc;
      prev_busy = busy;
    end else begin
      prev_busy = 1'b0;
    end
  end

  // Build a load stream: deterministic pattern or random legal bytes.
  task automatic gen_stream(input bit rnd, input bit bad_sum);
    int unsigned s8;
    stream.delete();
    stream.push_back(8'hA5);
    for (int i = 0; i < 61; i++)
      stream.push_back(rnd ? 8'($urandom_range(0, 26)) : 8'(i % 27));
    for (int j = 0; j < 27; j++)
      for (int k = 0; k < 8; k++)
        stream.push_back(rnd ? 8'($urandom) : 8'(j));
    s8 = 0;
    for (int i = 1; i < stream.size(); i++) s8 += stream[i];
`ifdef MCODE_CHECKSUM_EN
    stream.push_back(8'(s8) ^ {7'd0, bad_sum});
`else
    if (bad_sum) stream[0] = stream[0];
`endif
  endtask

  // Reference model: walk the stream by the loader's rules.
  task automatic model(output int used, output bit ok);
    logic [63:0] w;
    int unsigned s8;
    logic [7:0] b;
    used = 1;
    ok = 1'b0;
    if (stream[0] != 8'hA5) return;
    for (int i = 0; i < 61; i++) begin
      used = 2 + i;
      b = stream[1 + i];
      if (b >= 8'd27) return;
      exp_opc.push_back({6'(i), b[4:0]});
    end
    for (int j = 0; j < 27; j++) begin
      w = '0;
      for (int k = 0; k < 8; k++) w[8*k +: 8] = stream[62 + 8*j + k];
      exp_sub.push_back({5'(j), w[58:0]});
    end
    used = 278;
    ok = 1'b1;
`ifdef MCODE_CHECKSUM_EN
    s8 = 0;
    for (int i = 1; i < 278; i++) s8 += stream[i];
    used = 279;
    ok = (stream[278] == 8'(s8));
`else
    s8 = 0;
`endif
  endtask

  task automatic start_load();
    hs = 0; opc_seen = 0; sub_seen = 0; fall_cyc = -1; last_strobe_cyc = -2;
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
  endtask

  // Present n stream bytes with optional idle gaps and stray start pulses.
  task automatic drive(input int n, input int gap_pct, input bit pulses);
    bit acc;
    for (int i = 0; i < n; i++) begin
      for (int g = 0; g < 8 && $urandom_range(0, 99) < gap_pct; g++) begin
        in_valid = 1'b0;
        if (pulses && $urandom_range(0, 3) == 0) start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
      end
      in_valid = 1'b1;
      in_data = stream[i];
      if (pulses && $urandom_range(0, 9) == 0) start = 1'b1;
      acc = 1'b0;
      for (int t = 0; t < 200 && !acc; t++) begin
        @(negedge clk); acc = in_ready;
        @(posedge clk); #1 start = 1'b0;
      end
      if (!acc) begin
        chk("handshake_timeout", 64'd0, 64'd1);
        in_valid = 1'b0;
        return;
      end
    end
    in_valid = 1'b0;
  endtask

  task automatic finish_load(input string tag, input int used, input bit ok,
                             input int n_opc, input int n_sub);
    for (int t = 0; t < 500 && busy; t++) @(posedge clk);
    repeat (2) @(negedge clk);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, ok);
    chk({tag, "_error"}, error, !ok);
    chk({tag, "_in_ready"}, in_ready, 0);
    chk({tag, "_handshakes"}, hs, used);
    chk({tag, "_opc_count"}, opc_seen, n_opc);
    chk({tag, "_sub_count"}, sub_seen, n_sub);
    chk({tag, "_left_in_queues"}, exp_opc.size() + exp_sub.size(), 0);
    exp_opc.delete();
    exp_sub.delete();
  endtask

  task automatic full_run(input string tag, input bit rnd, input int gap_pct, input bit pulses);
    int used;
    bit ok;
    gen_stream(rnd, 1'b0);
    model(used, ok);
    start_load();
    chk({tag, "_busy_after_start"}, busy, 1);
    drive(used, gap_pct, pulses);
    finish_load(tag, used, ok, 61, 27);
  endtask

  initial begin
    int used;
    bit ok;
    #23;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_error", error, 0);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_strobes", {opc_we, sub_we}, 0);
    chk("rst_wdata", {opc_waddr, opc_wdata, sub_waddr, sub_wdata}, 0);
    @(negedge clk) rst_n = 1'b1;
    repeat (2) @(posedge clk);

    // Pattern load; strobe and busy fall share a cycle without checksum.
    full_run("full", 1'b0, 0, 1'b0);
`ifndef MCODE_CHECKSUM_EN
    chk("busy_falls_with_last_strobe", 64'(fall_cyc), 64'(last_strobe_cyc));
`endif

    // Bad header.
    gen_stream(1'b0, 1'b0);
    stream[0] = 8'h5A;
    model(used, ok);
    start_load();
    drive(used, 0, 1'b0);
    finish_load("bad_hdr", used, ok, 0, 0);

    // Illegal opcode index at entry 10, then recovery.
    gen_stream(1'b0, 1'b0);
    stream[11] = 8'd27;
    model(used, ok);
    start_load();
    drive(used, 0, 1'b0);
    finish_load("bad_opc", used, ok, 10, 0);
    full_run("recover", 1'b1, 0, 1'b0);

    // Random data with input gaps and ignored start pulses.
    for (int r = 0; r < 3; r++) full_run("gaps", 1'b1, 30, 1'b1);

    // Reset after byte 100.
    gen_stream(1'b1, 1'b0);
    model(used, ok);
    start_load();
    drive(100, 0, 1'b0);
    #1 rst_n = 1'b0;
    #1;
    chk("midrst_busy", busy, 0);
    chk("midrst_in_ready", in_ready, 0);
    chk("midrst_strobes", {opc_we, sub_we}, 0);
    chk("midrst_status", {done, error}, 0);
    chk("midrst_wdata", {opc_waddr, sub_waddr, sub_wdata}, 0);
    exp_opc.delete();
    exp_sub.delete();
    @(negedge clk) rst_n = 1'b1;
    full_run("after_rst", 1'b1, 10, 1'b0);

`ifdef MCODE_CHECKSUM_EN
    gen_stream(1'b1, 1'b1);
    model(used, ok);
    start_load();
    drive(used, 0, 1'b0);
    finish_load("bad_sum", used, ok, 61, 27);
    chk("bad_sum_model_rejects", ok, 0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

endmodule
